// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone command initiator.
package wb_init_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone signal bundle for wb_cmd_initiator.
interface wb_cmd_initiator_if
  import wb_init_pkg::*;
#(
  parameter int unsigned AW = 16
);

  logic [AW-1:0]     cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_we;
  logic              cmd_valid;
  logic              cmd_ready;

  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_valid;
  logic              rsp_ready;

  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] wb_rdata;
  logic              wb_we;
  logic              wb_cyc;
  logic              wb_ack;

  modport master (
    input  cmd_addr, cmd_wdata, cmd_we, cmd_valid,
    output cmd_ready,
    output rsp_rdata, rsp_err, rsp_valid,
    input  rsp_ready,
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    output cmd_addr, cmd_wdata, cmd_we, cmd_valid,
    input  cmd_ready,
    input  rsp_rdata, rsp_err, rsp_valid,
    output rsp_ready,
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );

endinterface

// File: rtl/wb_init_timeout.sv
// Stall counter for a Wishbone cycle; expired_c flags the cycle on which
// the TIMEOUT-th cycle without ack ends.
module wb_init_timeout
  import wb_init_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TO_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TO_CNT_W'(1);
    end
  end

  assign expired_c = en && (cnt_q == TO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_initiator.sv
// Valid/ready command stream to single Wishbone classic cycles.
// Optional stall abort is built when WB_INIT_TIMEOUT_EN is defined.
module wb_cmd_initiator
  import wb_init_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 255
)(
  input  logic                clk,
  input  logic                rst,
  wb_cmd_initiator_if.master  bus
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("wb_cmd_initiator: TIMEOUT must be within 1..65535");
  end

  state_e            state_q, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              we_q, we_n;
  logic              cyc_q, cyc_n;
  logic              valid_q, valid_n;
  logic              err_q, err_n;
  logic              accept_c;
  logic              expired_c;

`ifdef WB_INIT_TIMEOUT_EN
  logic stall_c;
  assign stall_c = (state_q == BUS) && !bus.wb_ack;

  wb_init_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_c),
    .en        (stall_c),
    .expired_c (expired_c)
  );
`else
  assign expired_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      we_q    <= we_n;
      cyc_q   <= cyc_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  // Ack is checked before expiry so an ack on the final cycle still succeeds.
  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    rdata_n  = rdata_q;
    we_n     = we_q;
    cyc_n    = cyc_q;
    valid_n  = valid_q;
    err_n    = err_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept_c = 1'b1;
          addr_n   = bus.cmd_addr;
          wdata_n  = bus.cmd_wdata;
          we_n     = bus.cmd_we;
          cyc_n    = 1'b1;
          state_n  = BUS;
        end
      end
      BUS: begin
        if (bus.wb_ack) begin
          rdata_n = we_q ? '0 : bus.wb_rdata;
          err_n   = 1'b0;
          cyc_n   = 1'b0;
          we_n    = 1'b0;
          valid_n = 1'b1;
          state_n = RSP;
        end else if (expired_c) begin
          rdata_n = '0;
          err_n   = 1'b1;
          cyc_n   = 1'b0;
          we_n    = 1'b0;
          valid_n = 1'b1;
          state_n = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        cyc_n   = 1'b0;
        we_n    = 1'b0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wb_addr   = addr_q;
  assign bus.wb_wdata  = wdata_q;
  assign bus.wb_we     = we_q;
  assign bus.wb_cyc    = cyc_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_valid = valid_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: vector table, reset and
// back-to-back sequences, and random transactions against a reference model.
module tb_wb_cmd_initiator;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_cmd_initiator_if #(.AW(16)) bus ();

  wb_cmd_initiator #(.AW(16), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-bank responder: acks ack_extra cycles after the first cycle it sees wb_cyc.
  logic [31:0] mem [256] = '{default: 32'h0};
  int ack_extra = 0;
  bit ack_never = 1'b0;
  int wait_cnt  = 0;

  always @(posedge clk) begin
    if (rst || !bus.wb_cyc || bus.wb_ack) begin
      bus.wb_ack <= 1'b0;
      wait_cnt   <= 0;
      if (rst) bus.wb_rdata <= 32'h0;
    end else if (!ack_never && wait_cnt >= ack_extra) begin
      bus.wb_ack   <= 1'b1;
      bus.wb_rdata <= mem[bus.wb_addr[7:0]];
      if (bus.wb_we) mem[bus.wb_addr[7:0]] <= bus.wb_wdata;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Reference model: whole transactions, from addressed memory and the stall rule.
  logic [31:0] ref_mem [256] = '{default: 32'h0};

  function automatic void model_txn(input logic [15:0] a, input logic [31:0] d,
                                    input logic we, input int extra, input bit never,
                                    output logic [31:0] rdata, output logic err,
                                    output int cc);
`ifdef WB_INIT_TIMEOUT_EN
    if (never || (2 + extra) > TO) begin
      rdata = 32'h0;
      err   = 1'b1;
      cc    = TO;
      return;
    end
`endif
    err   = 1'b0;
    cc    = 2 + extra;
    rdata = we ? 32'h0 : ref_mem[a[7:0]];
    if (we) ref_mem[a[7:0]] = d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [15:0] a, input logic [31:0] d,
                         input logic we, input int extra, input bit never, input int hold,
                         input logic [31:0] e_rdata, input logic e_err, input int e_cc);
    int lat;
    int cc;
    bit seen;
    bit stable;
    logic [31:0] rd0;
    logic er0;
    ack_extra = extra;
    ack_never = never;
    @(negedge clk);
    chk({tag, ".ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_we    = we;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 16'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_we    = 1'($urandom);
    lat = 1;
    cc = 0;
    seen = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.cmd_ready) stable = 1'b0;
      if (bus.wb_cyc) begin
        cc++;
        if (bus.wb_addr !== a || bus.wb_wdata !== d || bus.wb_we !== we) stable = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, ".rsp_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, ".bus_stable"}, 32'(stable), 32'd1);
    chk({tag, ".cyc_cycles"}, 32'(cc), 32'(e_cc));
    chk({tag, ".latency"}, 32'(lat), 32'(e_cc + 1));
    chk({tag, ".rdata"}, bus.rsp_rdata, e_rdata);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(e_err));
    chk({tag, ".cyc_off"}, {30'h0, bus.wb_cyc, bus.wb_we}, 32'h0);
    rd0 = bus.rsp_rdata;
    er0 = bus.rsp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== rd0 || bus.rsp_err !== er0 || bus.cmd_ready)
        stable = 1'b0;
    end
    if (hold > 0) chk({tag, ".rsp_hold"}, 32'(stable), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, {30'h0, bus.rsp_valid, bus.cmd_ready}, 32'h1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          extra;
    bit          never;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_cc;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] m_rd;
    logic m_err;
    int m_cc;
    bit quiet;
    int rsp_cyc[4];
    logic [31:0] rsp_dat[4];
    logic [31:0] exp_dat[4];
    int nr;
    int sent;
    logic [15:0] b_addr[4];
    logic [31:0] b_wdata[4];
    logic b_we[4];

    vecs.push_back('{16'h0001, 32'h0000_0A5A, 1'b1, 0, 1'b0, 0, 32'h0,         1'b0, 2});
    vecs.push_back('{16'h0001, 32'h0,         1'b0, 0, 1'b0, 0, 32'h0000_0A5A, 1'b0, 2});
    vecs.push_back('{16'h0002, 32'h1234_5678, 1'b1, 4, 1'b0, 3, 32'h0,         1'b0, 6});
    vecs.push_back('{16'h0002, 32'hFFFF_FFFF, 1'b0, 4, 1'b0, 3, 32'h1234_5678, 1'b0, 6});
`ifdef WB_INIT_TIMEOUT_EN
    vecs.push_back('{16'h0003, 32'hCAFE_F00D, 1'b1, 0, 1'b1, 1, 32'h0,         1'b1, TO});
    vecs.push_back('{16'h0001, 32'h0,         1'b0, 6, 1'b0, 0, 32'h0000_0A5A, 1'b0, TO});
    vecs.push_back('{16'h0003, 32'h0,         1'b0, 0, 1'b0, 0, 32'h0,         1'b0, 2});
`else
    vecs.push_back('{16'h0001, 32'h0,         1'b0, 15, 1'b0, 1, 32'h0000_0A5A, 1'b0, 17});
`endif

    bus.cmd_addr  = 16'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_we    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.cyc_we", {30'h0, bus.wb_cyc, bus.wb_we}, 32'h0);
    chk("reset.addr", 32'(bus.wb_addr), 32'h0);
    chk("reset.wdata", bus.wb_wdata, 32'h0);
    chk("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset.rsp", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h0);
    chk("reset.rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      model_txn(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].extra, vecs[i].never,
                m_rd, m_err, m_cc);
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we,
              vecs[i].extra, vecs[i].never, vecs[i].hold,
              vecs[i].e_rdata, vecs[i].e_err, vecs[i].e_cc);
    end

    // Reset on the second BUS cycle: cycle dropped, no response, write lost.
    ack_extra = 4;
    ack_never = 1'b0;
    @(negedge clk);
    bus.cmd_addr  = 16'h0005;
    bus.cmd_wdata = 32'hDEAD_BEEF;
    bus.cmd_we    = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_bus.cyc_before", 32'(bus.wb_cyc), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_bus.cyc_we", {30'h0, bus.wb_cyc, bus.wb_we}, 32'h0);
    chk("rst_bus.ready", 32'(bus.cmd_ready), 32'd1);
    quiet = 1'b1;
    repeat (8) begin
      if (bus.rsp_valid || bus.wb_cyc) quiet = 1'b0;
      @(negedge clk);
    end
    chk("rst_bus.no_rsp", 32'(quiet), 32'd1);
    model_txn(16'h0005, 32'h0, 1'b0, 0, 1'b0, m_rd, m_err, m_cc);
    run_txn("rst_bus.next", 16'h0005, 32'h0, 1'b0, 0, 1'b0, 0, m_rd, m_err, m_cc);

    // Reset while a response waits: response discarded.
    model_txn(16'h0006, 32'h0000_0007, 1'b1, 0, 1'b0, m_rd, m_err, m_cc);
    ack_extra = 0;
    @(negedge clk);
    bus.cmd_addr  = 16'h0006;
    bus.cmd_wdata = 32'h0000_0007;
    bus.cmd_we    = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin
        quiet = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_rsp.seen", 32'(quiet), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rsp.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp.ready", 32'(bus.cmd_ready), 32'd1);

    // Back-to-back with cmd_valid and rsp_ready held high.
    b_addr  = '{16'h0008, 16'h0008, 16'h0009, 16'h0006};
    b_wdata = '{32'h0000_0011, 32'h0, 32'h0000_0022, 32'h0};
    b_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      model_txn(b_addr[i], b_wdata[i], b_we[i], 0, 1'b0, m_rd, m_err, m_cc);
      exp_dat[i] = m_rd;
    end
    ack_extra = 0;
    nr = 0;
    sent = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid && nr < 4) begin
        rsp_cyc[nr] = c;
        rsp_dat[nr] = bus.rsp_rdata;
        nr++;
      end
      if (bus.cmd_ready) begin
        if (sent < 4) begin
          bus.cmd_addr  = b_addr[sent];
          bus.cmd_wdata = b_wdata[sent];
          bus.cmd_we    = b_we[sent];
          bus.cmd_valid = 1'b1;
          sent++;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("b2b.count", 32'(nr), 32'd4);
    for (int i = 0; i < nr; i++) begin
      chk($sformatf("b2b.rdata%0d", i), rsp_dat[i], exp_dat[i]);
      if (i > 0) chk($sformatf("b2b.gap%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd4);
    end

    // Random transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      logic [31:0] d;
      logic we;
      int extra;
      bit never;
      int hold;
      a     = 16'($urandom_range(0, 15));
      d     = $urandom;
      we    = 1'($urandom_range(0, 1));
      extra = $urandom_range(0, 5);
      hold  = $urandom_range(0, 2);
      never = 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
      never = ($urandom_range(0, 7) == 0);
`endif
      model_txn(a, d, we, extra, never, m_rd, m_err, m_cc);
      run_txn($sformatf("rand%0d", t), a, d, we, extra, never, hold, m_rd, m_err, m_cc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
